ethz_csa_accu_ctrl: RTL and testbench
=====================================

Name: ethz_csa_accu_ctrl

Overview:
- Sequencing controller for the SHA-256 accelerator's 3:2 carry-save adder datapath.
- Accepts a stream of WIDTH-bit operands, one per cycle, and folds each into a redundant (sum, carry) state through one CSA stage.
- On the group's last operand it performs a single carry-propagate resolve and emits the sum mod 2^WIDTH, e.g. T1 = h + Σ1 + Ch + K + W.
- Sits between the SHA round scheduler and the working-variable registers.

Parameters:
- WIDTH, 32, operand/result bit width.
- MAX_OPS, 8, maximum operands per group; must be >= 2. CW = $clog2(MAX_OPS+1).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous abort; discards the group and any pending result.
- op_valid_i  input  1  operand valid.
- op_ready_o  output  1  operand ready.
- op_data_i  input  WIDTH  operand.
- op_last_i  input  1  marks the final operand of a group.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  result accepted.
- res_data_o  output  WIDTH  group sum mod 2^WIDTH.
- res_count_o  output  CW  number of operands folded into res_data_o.
- res_trunc_o  output  1  group was closed by MAX_OPS, not by op_last_i.
- busy_o  output  1  high when state != ACCUM or count != 0.

Behaviour:
- Reset (async, rst_ni=0):
  - state=ACCUM; sum_q, carry_q, res_data_o = 0; count=0.
  - res_valid_o=0, res_count_o=0, res_trunc_o=0, busy_o=0.
  - op_ready_o=1 once reset is released.
  - Asserting reset mid-group or mid-output drops everything with no partial result.
- States: ACCUM, RESOLVE, OUTPUT.
- ACCUM:
  - op_ready_o=1.
  - On handshake (op_valid_i & op_ready_o):
    - sum_q <= sum_q ^ carry_q ^ op_data_i.
    - carry_q <= (maj(sum_q, carry_q, op_data_i) << 1), truncated to WIDTH; the MSB carry is discarded, so wrap is mod 2^WIDTH.
    - count <= count + 1.
  - Go to RESOLVE if op_last_i=1, or if count == MAX_OPS-1. In the second case set trunc=1; the op_last_i value is then ignored for trunc.
  - No handshake: hold all state.
- RESOLVE (exactly 1 cycle):
  - op_ready_o=0.
  - res_data_o <= sum_q + carry_q, truncated to WIDTH.
  - res_count_o <= count; res_trunc_o <= trunc.
  - Clear sum_q, carry_q, count and trunc to 0; go to OUTPUT.
- OUTPUT:
  - op_ready_o=0; res_valid_o=1.
  - res_data_o, res_count_o and res_trunc_o stay stable while res_valid_o & !res_ready_i.
  - On res_ready_i: res_valid_o=0 next cycle; go to ACCUM.
- Latency: last operand accepted at cycle t → res_valid_o=1 at t+2. Back-to-back groups have a throughput of n+2 cycles per group of n operands, with zero-stall sink.
- op_ready_o is combinational from state only; no dependence on op_valid_i.
- clear_i:
  - Synchronous, highest priority over all handshakes in the same cycle.
  - Next state ACCUM; sum_q, carry_q, count, trunc = 0; res_valid_o=0.
  - An operand presented while clear_i=1 is not consumed.
- Data outputs res_data_o, res_count_o and res_trunc_o hold their last values after handshake until the next RESOLVE.

Test Plan:
- Reset then group {1,2,3,4,5}, last on 5, res_ready_i=1 → res_data_o=0x0000000F, res_count_o=5, res_trunc_o=0, res_valid_o exactly 2 cycles after the last handshake.
- Wrap-around: {0xFFFFFFFF, 0x00000001, 0x00000002, last} → res_data_o=0x00000002, count=3.
- Single operand {0xDEADBEEF, last} → res_data_o=0xDEADBEEF, count=1; op_ready_o low for 2 cycles, then high after sink accepts.
- Backpressure: group {0x10,0x20, last}, hold res_ready_i=0 for 5 cycles → res_valid_o=1 and res_data_o=0x30 stable; op_ready_o=0 throughout; release → returns to ACCUM.
- Truncation with MAX_OPS=8: nine operands of 1, last only on the ninth → first result 0x8 with count=8, trunc=1; second result 0x1 with count=1, trunc=0.
- clear_i pulsed after 3 operands, with op_valid_i=1 in the same cycle → that operand is not consumed; next group {7, last} yields 0x7 with count=1. Also: rst_ni low during OUTPUT → res_valid_o drops to 0 asynchronously.

Source files
------------

// File: rtl/ethz_csa_accu_ctrl.sv
// Carry-save operand accumulator for the SHA-256 datapath: folds a group of operands
// into redundant sum/carry form, then resolves once with a single carry-propagate add.
module ethz_csa_accu_ctrl #(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned MAX_OPS = 8,
  localparam int unsigned CW      = $clog2(MAX_OPS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [WIDTH-1:0] op_data_i,
  input  logic             op_last_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic [CW-1:0]    res_count_o,
  output logic             res_trunc_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_e;

  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_OPS - 1);

  function automatic logic [WIDTH-1:0] maj(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] c);
    maj = (a & b) | (a & c) | (b & c);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic             trunc_q, trunc_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [CW-1:0]    res_count_q, res_count_d;
  logic             res_trunc_q, res_trunc_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      carry_q     <= '0;
      count_q     <= '0;
      trunc_q     <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_trunc_q <= res_trunc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_trunc_d = res_trunc_q;

    if (clear_i) begin
      // Abort wins over every handshake; the last delivered result stays visible.
      state_d = ACCUM;
      sum_d   = '0;
      carry_d = '0;
      count_d = '0;
      trunc_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (op_valid_i) begin
            sum_d   = sum_q ^ carry_q ^ op_data_i;
            carry_d = maj(sum_q, carry_q, op_data_i) << 1;
            count_d = count_q + CW'(1);
            if (count_q == LAST_CNT) begin
              trunc_d = 1'b1;
              state_d = RESOLVE;
            end else if (op_last_i) begin
              state_d = RESOLVE;
            end
          end
        end
        RESOLVE: begin
          res_data_d  = sum_q + carry_q;
          res_count_d = count_q;
          res_trunc_d = trunc_q;
          sum_d       = '0;
          carry_d     = '0;
          count_d     = '0;
          trunc_d     = 1'b0;
          state_d     = OUTPUT;
        end
        OUTPUT: begin
          if (res_ready_i) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign op_ready_o  = (state_q == ACCUM);
  assign res_valid_o = (state_q == OUTPUT);
  assign res_data_o  = res_data_q;
  assign res_count_o = res_count_q;
  assign res_trunc_o = res_trunc_q;
  assign busy_o      = (state_q != ACCUM) || (count_q != '0);

endmodule

// File: tb/tb_ethz_csa_accu_ctrl.sv
// Directed bench for ethz_csa_accu_ctrl: hand-computed group sums, latency,
// backpressure, truncation, clear and asynchronous reset.
module tb_ethz_csa_accu_ctrl;

  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_data;
  logic             op_last;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [CW-1:0]    res_count;
  logic             res_trunc;
  logic             busy;

  int tests = 0;
  int fails = 0;

  ethz_csa_accu_ctrl #(.WIDTH(WIDTH), .MAX_OPS(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_data_i   (op_data),
    .op_last_i   (op_last),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_count_o (res_count),
    .res_trunc_o (res_trunc),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    op_valid = 1'b1;
    op_data  = d;
    op_last  = last;
    chk("op_ready_at_send", {31'd0, op_ready}, 32'd1);
    tick();
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  // Called right after the last operand's edge; res_ready must already be 1.
  task automatic expect_result(input string tag, input logic [31:0] d,
                               input logic [31:0] cnt, input logic tr);
    chk({tag, "_resolve_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_resolve_ready"}, {31'd0, op_ready}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_data"},  res_data, d);
    chk({tag, "_count"}, {28'd0, res_count}, cnt);
    chk({tag, "_trunc"}, {31'd0, res_trunc}, {31'd0, tr});
    chk({tag, "_out_ready"}, {31'd0, op_ready}, 32'd0);
    tick();
    chk({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_back_ready"}, {31'd0, op_ready}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; op_valid = 1'b0; op_data = '0;
    op_last = 1'b0; res_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data",  res_data, 32'd0);
    chk("rst_count", {28'd0, res_count}, 32'd0);
    chk("rst_trunc", {31'd0, res_trunc}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, op_ready}, 32'd1);

    // {1,2,3,4,5} -> 0xF
    res_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(i, 1'b0);
    chk("g1_busy_mid", {31'd0, busy}, 32'd1);
    send(5, 1'b1);
    expect_result("g1", 32'h0000_000F, 5, 1'b0);

    // wrap-around
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0002, 1'b1);
    expect_result("wrap", 32'h0000_0002, 3, 1'b0);

    // single operand
    send(32'hDEAD_BEEF, 1'b1);
    expect_result("single", 32'hDEAD_BEEF, 1, 1'b0);

    // backpressure
    res_ready = 1'b0;
    send(32'h10, 1'b0);
    send(32'h20, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_data",  res_data, 32'h30);
      chk("bp_count", {28'd0, res_count}, 32'd2);
      chk("bp_ready", {31'd0, op_ready}, 32'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, res_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, op_ready}, 32'd1);
    chk("bp_data_hold", res_data, 32'h30);

    // truncation: eight ones close the group, the ninth forms its own
    for (int i = 0; i < 8; i++) send(1, 1'b0);
    expect_result("trunc1", 32'h8, 8, 1'b1);
    send(1, 1'b1);
    expect_result("trunc2", 32'h1, 1, 1'b0);

    // clear with a simultaneous operand
    send(1, 1'b0);
    send(2, 1'b0);
    send(3, 1'b0);
    op_valid = 1'b1; op_data = 32'd100; clear = 1'b1;
    tick();
    op_valid = 1'b0; clear = 1'b0;
    chk("clr_busy",  {31'd0, busy}, 32'd0);
    chk("clr_ready", {31'd0, op_ready}, 32'd1);
    chk("clr_valid", {31'd0, res_valid}, 32'd0);
    send(7, 1'b1);
    expect_result("post_clr", 32'h7, 1, 1'b0);

    // async reset during OUTPUT
    res_ready = 1'b0;
    send(32'h55, 1'b1);
    tick();
    chk("rst_out_valid_before", {31'd0, res_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_out_data",  res_data, 32'd0);
    chk("rst_out_busy",  {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();
    chk("rst_out_ready", {31'd0, op_ready}, 32'd1);
    send(32'hA, 1'b0);
    send(32'hB, 1'b1);
    expect_result("after_rst", 32'h15, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
